// File: rtl/ror_seq.sv
// rtl/ror_seq.sv - iterative 32-bit rotate-right sequencer (IDLE/RUN/DONE)
// Define ROR_SEQ_FAST_EN to rotate up to 4 positions per RUN cycle instead of 1.
module ror_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] Rb,
    input  logic [31:0] Rc,
    output logic [31:0] Ra,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [31:0] ra_q, ra_d;
    logic [4:0]  n_q, n_d;
    logic [2:0]  step;
    logic [4:0]  n_rem;
    logic [31:0] work_rot;
    logic        unused_rc;

    // Only the low five bits of the count matter: rotation is mod 32.
    assign unused_rc = ^Rc[31:5];

    always_comb begin
`ifdef ROR_SEQ_FAST_EN
        step = (n_q > 5'd4) ? 3'd4 : n_q[2:0];
`else
        step = 3'd1;
`endif
        n_rem = n_q - {2'b00, step};
        case (step)
            3'd1:    work_rot = {work_q[0],   work_q[31:1]};
            3'd2:    work_rot = {work_q[1:0], work_q[31:2]};
            3'd3:    work_rot = {work_q[2:0], work_q[31:3]};
            3'd4:    work_rot = {work_q[3:0], work_q[31:4]};
            default: work_rot = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        n_d     = n_q;
        ra_d    = ra_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = Rb;
                    n_d    = Rc[4:0];
                    if (Rc[4:0] == 5'd0) begin
                        ra_d    = Rb;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                work_d = work_rot;
                n_d    = n_rem;
                // Ra only ever sees the finished value, never a partial rotation.
                if (n_rem == 5'd0) begin
                    ra_d    = work_rot;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            work_q  <= 32'h0;
            n_q     <= 5'd0;
            ra_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            n_q     <= n_d;
            ra_q    <= ra_d;
        end
    end

    assign Ra   = ra_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_ror_seq.sv
// tb/tb_ror_seq.sv - scoreboard bench for ror_seq (honours ROR_SEQ_FAST_EN)
module tb_ror_seq;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] Rb;
    logic [31:0] Rc;
    logic [31:0] Ra;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] ra;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          total;
    int          bad;
    logic [31:0] last_ra;

    ror_seq dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .Rb    (Rb),
        .Rc    (Rc),
        .Ra    (Ra),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_ror(input logic [31:0] b, input logic [31:0] c);
        logic [31:0] r;
        r = b;
        for (int i = 0; i < int'(c[4:0]); i++) r = {r[0], r[31:1]};
        return r;
    endfunction

    function automatic int model_lat(input logic [31:0] c);
        int n;
        n = int'(c[4:0]);
`ifdef ROR_SEQ_FAST_EN
        return (n + 3) / 4;
`else
        return n;
`endif
    endfunction

    // Drive one request; E0 is the posedge between the two negedges here.
    task automatic issue(input logic [31:0] b, input logic [31:0] c);
        exp_t e;
        e.ra  = model_ror(b, c);
        e.lat = model_lat(c);
        sb.push_back(e);
        @(negedge clk);
        last_ra = Ra;
        start = 1'b1;
        Rb    = b;
        Rc    = c;
        @(negedge clk);
        start = 1'b0;
        Rb    = $urandom;
        Rc    = $urandom;
    endtask

    task automatic check_done(input string name, input bit inject);
        exp_t e;
        int   cyc;
        int   pulses;
        e   = sb.pop_front();
        cyc = 0;
        while (!done && cyc < 100) begin
            total++;
            if (busy !== 1'b1 || Ra !== last_ra) begin
                bad++;
                $display("FAIL %s run: busy=%b Ra=%h required busy=1 Ra=%h", name, busy, Ra, last_ra);
            end
            if (inject && cyc == 0) begin
                start = 1'b1;
                Rb    = 32'hFFFF_FFFF;
                Rc    = 32'd5;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout: done never seen, required after %0d cycles", name, e.lat);
            return;
        end
        total++;
        if (Ra !== e.ra) begin
            bad++;
            $display("FAIL %s result: Ra=%h required %h", name, Ra, e.ra);
        end
        total++;
        if (cyc != e.lat || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s latency: cycles=%0d busy=%b required %0d busy=1", name, cyc, busy, e.lat);
        end
        last_ra = Ra;
        pulses  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        total++;
        if (pulses != 0 || busy !== 1'b0 || Ra !== last_ra) begin
            bad++;
            $display("FAIL %s after: extra_done=%0d busy=%b Ra=%h required 0 0 %h", name, pulses, busy, Ra, last_ra);
        end
    endtask

    task automatic test_reset();
        clr = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (Ra !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset: Ra=%h busy=%b done=%b required 0 0 0", Ra, busy, done);
        end
        clr = 1'b1;
        @(negedge clk);
        last_ra = Ra;
    endtask

    task automatic test_vectors();
        issue(32'h0000_0001, 32'd1);
        check_done("rc1", 1'b0);
        issue(32'h1234_5678, 32'd4);
        check_done("rc4", 1'b0);
        issue(32'hDEAD_BEEF, 32'd32);
        check_done("rc32", 1'b0);
        issue(32'h8000_0001, 32'd31);
        check_done("rc31", 1'b0);
        issue(32'hA5A5_0F0F, 32'd5);
        check_done("rc5", 1'b0);
    endtask

    task automatic test_ignore_start();
        issue(32'h0000_000F, 32'hFFFF_FFE3);
        check_done("ignore", 1'b1);
    endtask

    task automatic test_abort();
        int pulses;
        @(negedge clk);
        start = 1'b1;
        Rb    = 32'h1234_5678;
        Rc    = 32'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        total++;
        if (Ra !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort: Ra=%h busy=%b done=%b required 0 0 0", Ra, busy, done);
        end
        clr    = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL abort_quiet: active_cycles=%0d required 0", pulses);
        end
        last_ra = Ra;
        issue(32'h1234_5678, 32'd20);
        check_done("after_abort", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            issue($urandom, $urandom);
            check_done("random", 1'b0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr   = 1'b0;
        start = 1'b0;
        Rb    = 32'h0;
        Rc    = 32'h0;
        last_ra = 32'h0;
        test_reset();
        test_vectors();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ror_seq.md
ROR_SEQ -- requirements
Module: ror_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, with ports named as in the codebase: clk and clr.
REQ-002 Port clk SHALL be: input, 1 bit, rising-edge clock.
REQ-003 Port clr SHALL be: input, 1 bit, synchronous active-low reset.
REQ-004 Port start SHALL be: input, 1 bit, operation request, sampled in IDLE only.
REQ-005 Port Rb SHALL be: input, 32 bits, operand to rotate.
REQ-006 Port Rc SHALL be: input, 32 bits, rotate count; only Rc[4:0] is used.
REQ-007 Port Ra SHALL be: output, 32 bits, registered result.
REQ-008 Port busy SHALL be: output, 1 bit, high while state is not IDLE.
REQ-009 Port done SHALL be: output, 1 bit, one-cycle pulse marking a valid Ra.

Function
REQ-010 The block SHALL perform rotate right of Rb by n = Rc mod 32, iteratively, as the multi-cycle counterpart of the combinational rotate-left unit.
REQ-011 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE with start=1 at edge E0, the block SHALL latch Rb into a work register and Rc[4:0] into a count register n.
REQ-013 At E0, the block SHALL go to DONE if n=0, otherwise to RUN.
REQ-014 At each RUN edge, the block SHALL rotate the work register right by step positions and decrement n by step.
REQ-015 The value of step SHALL be 1 (see REQ-026 for the alternative).
REQ-016 In RUN, the block SHALL go to DONE on the edge where n reaches 0; Ra SHALL load the final work value on that same edge.
REQ-017 The n=0 path SHALL load Ra with Rb at E0.
REQ-018 done SHALL be high for exactly the single cycle spent in DONE, and DONE SHALL return to IDLE unconditionally at the next edge.
REQ-019 Latency: with 1-bit steps, done SHALL assert in the cycle following edge E0+n.
REQ-020 Ra SHALL hold its value from DONE until the next completed operation, and SHALL NOT show intermediate RUN values.
REQ-021 start SHALL be ignored in RUN and DONE; there is no queueing.
REQ-022 Changes on Rb and Rc after E0 SHALL NOT affect the operation in progress.

Reset
REQ-023 When clr=0 at a rising edge, the block SHALL set state to IDLE, Ra to 0x00000000, busy to 0, done to 0, and the work and count registers to 0.
REQ-024 clr=0 during RUN or DONE SHALL abort the operation with no done pulse; clr SHALL take priority over start.

Configuration
REQ-025 Macro ROR_SEQ_FAST_EN SHALL select the step size.
REQ-026 With ROR_SEQ_FAST_EN defined, step SHALL be min(n,4), and done SHALL assert in the cycle following edge E0+ceil(n/4).
REQ-027 Without ROR_SEQ_FAST_EN, step SHALL be 1; results, ports and handshake SHALL be identical in both builds.

Verification
REQ-028 Rb=0x00000001, Rc=1, start -> Ra=0x80000000, done one cycle after E0+1, busy high for 2 cycles.
REQ-029 Rb=0x12345678, Rc=4 -> Ra=0x81234567; done after E0+4 (after E0+1 with FAST).
REQ-030 Rb=0xDEADBEEF, Rc=32 (n=0) -> Ra=0xDEADBEEF, done in cycle after E0, no RUN cycles.
REQ-031 Rb=0x80000001, Rc=31 -> Ra=0x00000003; done after E0+31 (after E0+8 with FAST).
REQ-032 Rb=0x0000000F, Rc=0xFFFFFFE3 -> Ra=0xE0000001; a second start pulse mid-RUN with Rb=0xFFFFFFFF -> ignored, single done.
REQ-033 Start Rb=0x12345678, Rc=20, then clr=0 at E0+3 -> next cycle Ra=0, busy=0, done never asserts; a subsequent start after clr=1 completes normally.
